// File: rtl/point_stream_out.sv
// Output stage for the scalar-multiplication datapath: captures the final affine
// point and streams x then y, least-significant word first, over valid/ready.
module point_stream_out #(
  parameter int DATA_W = 64  // must divide 256: 32, 64, 128 or 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [254:0]      i_x,
  input  logic [254:0]      i_y,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_drop
);

  localparam int BEATS = 512 / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t            r_state, w_state_next;
  logic [511:0]      r_buf, w_buf_next;
  logic [BW-1:0]     r_beat, w_beat_next;
  logic              r_drop, w_drop_next;
  logic [DATA_W-1:0] w_words [BEATS];
  logic              w_last;
  logic              w_xfer;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
      assign w_words[gi] = r_buf[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_last = (r_state == S_SEND) && (r_beat == LAST_BEAT);
  assign w_xfer = (r_state == S_SEND) && i_ready;

  always_comb begin
    w_state_next = r_state;
    w_buf_next   = r_buf;
    w_beat_next  = r_beat;
    w_drop_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_buf_next   = {1'b0, i_y, 1'b0, i_x};
          w_beat_next  = '0;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer && w_last) begin
          // A start coinciding with the final transfer chains the next point without a bubble.
          w_beat_next = '0;
          if (i_start) begin
            w_buf_next = {1'b0, i_y, 1'b0, i_x};
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          if (w_xfer) begin
            w_beat_next = r_beat + BW'(1);
          end
          w_drop_next = i_start;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_beat  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_buf   <= w_buf_next;
      r_beat  <= w_beat_next;
      r_drop  <= w_drop_next;
    end
  end

  assign o_valid = (r_state == S_SEND);
  assign o_busy  = (r_state == S_SEND);
  assign o_last  = w_last;
  assign o_data  = w_words[r_beat];
  assign o_drop  = r_drop;

endmodule

// File: tb/tb_point_stream_out.sv
// Scoreboard bench for point_stream_out: expected words are queued when a start
// is driven and compared as the DUT transfers them.
module tb_point_stream_out;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [254:0]  i_x, i_y;
  logic [DW-1:0] o_data;
  logic          o_valid, i_ready, o_last, o_busy, o_drop;

  int n_vec  = 0;
  int n_err  = 0;
  int n_xfer = 0;
  int n_drop = 0;

  logic [DW:0] q[$];  // {last, data}

  point_stream_out #(.DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_x(i_x), .i_y(i_y),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_busy(o_busy), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic void push_point(input logic [254:0] x, input logic [254:0] y);
    logic [511:0] b;
    b = {1'b0, y, 1'b0, x};
    for (int k = 0; k < 8; k++) q.push_back({k == 7, b[k*DW +: DW]});
  endfunction

  // Monitor: scoreboard pop on transfer, hold check under stall.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   e;
  always @(negedge clk) begin
    if (i_rst) begin
      stall_prev = 1'b0;
    end else begin
      chk("busy_eq_valid", 256'(o_busy), 256'(o_valid));
      if (stall_prev) begin
        chk("hold_valid", 256'(o_valid), 256'(1));
        chk("hold_data", 256'(o_data), 256'(prev_data));
        chk("hold_last", 256'(o_last), 256'(prev_last));
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("extra_word", 256'(1), 256'(0));
        end else begin
          e = q.pop_front();
          chk("word_data", 256'(o_data), 256'(e[DW-1:0]));
          chk("word_last", 256'(o_last), 256'(e[DW]));
        end
        $display("xfer %0d data=%h last=%b", n_xfer, o_data, o_last);
        n_xfer++;
      end
      if (!o_valid) chk("idle_last", 256'(o_last), 256'(0));
      if (o_drop) n_drop++;
      stall_prev = o_valid && !i_ready;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  task automatic start_pt(input logic [254:0] x, input logic [254:0] y, input bit push);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_x = x;
    i_y = y;
    i_ready = 1'b1;
    if (push) push_point(x, y);
  endtask

  task automatic drain(input bit bp);
    int c;
    logic [3:0] pat;
    c = 0;
    pat = 4'b1001;
    do begin
      @(posedge clk); #1;
      i_start = 1'b0;
      i_ready = bp ? pat[c % 4] : 1'b1;
      c++;
    end while (q.size() != 0 && c < 200);
    if (q.size() != 0) chk("drain_timeout", 256'(q.size()), 256'(0));
    i_ready = 1'b1;
  endtask

  initial begin
    logic [255:0] t;
    int d0, x0, c;
    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_x = '0; i_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 256'(o_valid), 256'(0));
    chk("rst_last", 256'(o_last), 256'(0));
    chk("rst_busy", 256'(o_busy), 256'(0));
    chk("rst_drop", 256'(o_drop), 256'(0));
    chk("rst_data", 256'(o_data), 256'(0));
    @(posedge clk); #1;
    i_rst = 1'b0;

    // Basic stream
    x0 = n_xfer;
    start_pt(255'd1, 255'd2, 1);
    chk("pre_valid", 256'(o_valid), 256'(0));
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("lat1_valid", 256'(o_valid), 256'(1));
    drain(0);
    chk("post_valid", 256'(o_valid), 256'(0));
    chk("post_busy", 256'(o_busy), 256'(0));
    chk("basic_count", 256'(n_xfer - x0), 256'(8));

    // Width boundary
    start_pt({255{1'b1}}, {255{1'b1}}, 1);
    drain(0);

    // Back-pressure
    x0 = n_xfer;
    t = {4{64'h0123_4567_89ab_cdef}};
    i_x = t[254:0];
    t = {4{64'hfedc_ba98_7654_3210}};
    start_pt(i_x, t[254:0], 1);
    drain(1);
    chk("bp_count", 256'(n_xfer - x0), 256'(8));
    chk("bp_idle", 256'(o_valid), 256'(0));

    // Back-to-back
    d0 = n_drop;
    start_pt(255'd5, 255'd6, 1);
    c = 0;
    do begin
      @(posedge clk); #1;
      i_start = 1'b0;
      c++;
    end while (!o_last && c < 50);
    chk("b2b_reach_last", 256'(o_last), 256'(1));
    i_start = 1'b1; i_x = 255'd3; i_y = 255'd4;
    push_point(255'd3, 255'd4);
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("b2b_valid", 256'(o_valid), 256'(1));
    chk("b2b_first", 256'(o_data), 256'(3));
    drain(0);
    chk("b2b_nodrop", 256'(n_drop - d0), 256'(0));

    // Overrun
    d0 = n_drop;
    start_pt(255'h11, 255'h22, 1);
    repeat (3) begin @(posedge clk); #1; i_start = 1'b0; end
    i_start = 1'b1; i_x = 255'd9; i_y = 255'd10;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("ovr_drop_hi", 256'(o_drop), 256'(1));
    @(posedge clk); #1;
    chk("ovr_drop_lo", 256'(o_drop), 256'(0));
    drain(0);
    chk("ovr_drop_count", 256'(n_drop - d0), 256'(1));

    // Reset mid-stream, with a start during reset that must be ignored
    start_pt(255'h55, 255'h66, 1);
    repeat (6) begin @(posedge clk); #1; i_start = 1'b0; end
    i_rst = 1'b1;
    i_start = 1'b1; i_x = 255'h77; i_y = 255'h78;
    q.delete();
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_start = 1'b0;
    chk("mrst_valid", 256'(o_valid), 256'(0));
    chk("mrst_last", 256'(o_last), 256'(0));
    chk("mrst_busy", 256'(o_busy), 256'(0));
    @(posedge clk); #1;
    chk("mrst_still_idle", 256'(o_valid), 256'(0));
    x0 = n_xfer;
    start_pt(255'habc, 255'hdef, 1);
    drain(0);
    chk("mrst_count", 256'(n_xfer - x0), 256'(8));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
